// File: rtl/intersection_sequencer_if.sv
// rtl/intersection_sequencer_if.sv - request, datapath and result signals of the intersection sequencer
interface intersection_sequencer_if #(
    parameter int FIXED_W = 32
);
    logic                   req_valid;
    logic                   req_ready;
    logic [3*FIXED_W-1:0]   ray_orig;
    logic [3*FIXED_W-1:0]   ray_dir;
    logic [3*FIXED_W-1:0]   vert0;
    logic [3*FIXED_W-1:0]   vert1;
    logic [3*FIXED_W-1:0]   vert2;
    logic [3*FIXED_W-1:0]   dp_rdir;
    logic [3*FIXED_W-1:0]   dp_t1;
    logic [3*FIXED_W-1:0]   dp_e1;
    logic [3*FIXED_W-1:0]   dp_e2;
    logic                   dp_sel1;
    logic                   dp_sel2;
    logic [FIXED_W-1:0]     dp_det;
    logic [FIXED_W-1:0]     dp_u;
    logic [FIXED_W-1:0]     dp_v;
    logic [FIXED_W-1:0]     dp_t;
    logic                   res_valid;
    logic                   res_ready;
    logic                   res_hit;
    logic [FIXED_W-1:0]     res_t;
    logic [FIXED_W-1:0]     res_u;
    logic [FIXED_W-1:0]     res_v;

    modport master (
        output req_valid, ray_orig, ray_dir, vert0, vert1, vert2,
        output dp_det, dp_u, dp_v, dp_t, res_ready,
        input  req_ready, dp_rdir, dp_t1, dp_e1, dp_e2, dp_sel1, dp_sel2,
        input  res_valid, res_hit, res_t, res_u, res_v
    );

    modport slave (
        input  req_valid, ray_orig, ray_dir, vert0, vert1, vert2,
        input  dp_det, dp_u, dp_v, dp_t, res_ready,
        output req_ready, dp_rdir, dp_t1, dp_e1, dp_e2, dp_sel1, dp_sel2,
        output res_valid, res_hit, res_t, res_u, res_v
    );
endinterface

// File: rtl/intersection_sequencer.sv
// rtl/intersection_sequencer.sv - operand front-end and phase sequencer for the ray/triangle datapath
module intersection_sequencer #(
    parameter int FIXED_W   = 32,
    parameter int FRAC_W    = 16,
    parameter int PHASE_CYC = 3,
    parameter int EPS       = 1
) (
    input logic                      clock,
    input logic                      reset_n,
    intersection_sequencer_if.slave  bus
);
    localparam int VW = 3 * FIXED_W;
    localparam int CW = $clog2(PHASE_CYC);
    localparam logic signed [FIXED_W:0] ONE   = (FIXED_W+1)'(1) << FRAC_W;
    localparam logic signed [FIXED_W:0] EPS_X = (FIXED_W+1)'(EPS);

    typedef enum logic [2:0] {IDLE, LOAD, PH_U, PH_V, PH_T, EVAL, DONE} state_t;

    state_t                 state, state_d;
    logic [CW-1:0]          cnt;
    logic                   phase_last, phase_first;
    logic                   req_ready_d, res_valid_d, sel1_d, sel2_d;
    logic [VW-1:0]          orig_q, dir_q, v0_q, v1_q, v2_q;
    logic [FIXED_W-1:0]     u_q, v_q;
    logic                   det_fail;
    logic signed [FIXED_W:0] det_x, det_abs, t_x, uv_sum;
    logic                   det_small, hit;

    function automatic logic [VW-1:0] vsub(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [VW-1:0] r;
        r = '0;
        for (int i = 0; i < 3; i++)
            r[i*FIXED_W +: FIXED_W] = a[i*FIXED_W +: FIXED_W] - b[i*FIXED_W +: FIXED_W];
        return r;
    endfunction

    assign phase_last  = (cnt == CW'(PHASE_CYC - 1));
    assign phase_first = (cnt == '0);

    // One extra bit keeps |det| and u+v exact, including the most negative det.
    always_comb begin
        det_x     = $signed({bus.dp_det[FIXED_W-1], bus.dp_det});
        det_abs   = det_x[FIXED_W] ? -det_x : det_x;
        det_small = (det_abs <= EPS_X);
        t_x       = $signed({bus.dp_t[FIXED_W-1], bus.dp_t});
        uv_sum    = $signed({u_q[FIXED_W-1], u_q}) + $signed({v_q[FIXED_W-1], v_q});
        hit       = !det_fail && !u_q[FIXED_W-1] && !v_q[FIXED_W-1]
                    && (uv_sum <= ONE) && (t_x > EPS_X);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.req_ready <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.dp_sel1   <= 1'b0;
            bus.dp_sel2   <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= (state_d != state) ? '0 : cnt + 1'b1;
            bus.req_ready <= req_ready_d;
            bus.res_valid <= res_valid_d;
            bus.dp_sel1   <= sel1_d;
            bus.dp_sel2   <= sel2_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (bus.req_valid) state_d = LOAD;
            LOAD: state_d = PH_U;
            PH_U: if (phase_last) state_d = det_small ? EVAL : PH_V;
            PH_V: if (phase_last) state_d = PH_T;
            PH_T: if (phase_last) state_d = EVAL;
            EVAL: state_d = DONE;
            DONE: if (bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and select outputs are decoded from the next state and registered.
    always_comb begin
        req_ready_d = (state_d == IDLE);
        res_valid_d = (state_d == DONE);
        sel1_d      = (state_d == PH_V) || (state_d == PH_T) || (state_d == EVAL);
        sel2_d      = (state_d == PH_T);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            orig_q      <= '0;
            dir_q       <= '0;
            v0_q        <= '0;
            v1_q        <= '0;
            v2_q        <= '0;
            bus.dp_rdir <= '0;
            bus.dp_t1   <= '0;
            bus.dp_e1   <= '0;
            bus.dp_e2   <= '0;
            u_q         <= '0;
            v_q         <= '0;
            det_fail    <= 1'b0;
            bus.res_hit <= 1'b0;
            bus.res_t   <= '0;
            bus.res_u   <= '0;
            bus.res_v   <= '0;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                orig_q <= bus.ray_orig;
                dir_q  <= bus.ray_dir;
                v0_q   <= bus.vert0;
                v1_q   <= bus.vert1;
                v2_q   <= bus.vert2;
            end
            if (state == LOAD) begin
                bus.dp_rdir <= dir_q;
                bus.dp_e1   <= vsub(v1_q, v0_q);
                bus.dp_e2   <= vsub(v2_q, v0_q);
                bus.dp_t1   <= vsub(orig_q, v0_q);
            end
            if (state == PH_U && phase_last) det_fail <= det_small;
            if (state == PH_V && phase_first) u_q <= bus.dp_u;
            if (state == PH_T && phase_first) v_q <= bus.dp_v;
            if (state == EVAL) begin
                bus.res_hit <= hit;
                bus.res_t   <= det_fail ? '0 : bus.dp_t;
                bus.res_u   <= det_fail ? '0 : u_q;
                bus.res_v   <= det_fail ? '0 : v_q;
            end
        end
    end
endmodule

// File: tb/tb_intersection_sequencer.sv
// tb/tb_intersection_sequencer.sv - directed scoreboard bench with a behavioural Moller datapath
module tb_intersection_sequencer;
    localparam int W = 32;
    localparam logic [31:0] ONE  = 32'h0001_0000;
    localparam logic [31:0] NEG1 = 32'hFFFF_0000;

    typedef struct {
        logic        hit;
        logic [31:0] t, u, v;
        int          lat;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   hs2 = 0;
    exp_t q3[$];
    exp_t q2[$];
    exp_t e2v;

    always #5 clock = ~clock;

    intersection_sequencer_if #(.FIXED_W(W)) bus3();
    intersection_sequencer_if #(.FIXED_W(W)) bus2();

    intersection_sequencer #(.FIXED_W(W), .FRAC_W(16), .PHASE_CYC(3), .EPS(1)) dut3 (
        .clock(clock), .reset_n(reset_n), .bus(bus3.slave));
    intersection_sequencer #(.FIXED_W(W), .FRAC_W(16), .PHASE_CYC(2), .EPS(1)) dut2 (
        .clock(clock), .reset_n(reset_n), .bus(bus2.slave));

    assign bus2.req_valid = bus3.req_valid;
    assign bus2.ray_orig  = bus3.ray_orig;
    assign bus2.ray_dir   = bus3.ray_dir;
    assign bus2.vert0     = bus3.vert0;
    assign bus2.vert1     = bus3.vert1;
    assign bus2.vert2     = bus3.vert2;
    assign bus2.res_ready = 1'b1;

    function automatic longint comp(input logic [95:0] vec, input int i);
        return longint'($signed(vec[95-32*i -: 32]));
    endfunction
    function automatic longint fm(input longint a, input longint b);
        return (a * b) >>> 16;
    endfunction
    function automatic longint fdiv(input longint n, input longint d);
        return (d == 0) ? 0 : ((n <<< 16) / d);
    endfunction

    // Returns {det, u, v, t} for the current operands.
    function automatic logic [127:0] moller(input logic [95:0] rdir, t1, e1, e2);
        longint d[3], o[3], a[3], b[3], p[3], q[3];
        longint det, un, vn, tn;
        for (int i = 0; i < 3; i++) begin
            d[i] = comp(rdir, i); o[i] = comp(t1, i);
            a[i] = comp(e1, i);   b[i] = comp(e2, i);
        end
        p[0] = fm(d[1], b[2]) - fm(d[2], b[1]);
        p[1] = fm(d[2], b[0]) - fm(d[0], b[2]);
        p[2] = fm(d[0], b[1]) - fm(d[1], b[0]);
        q[0] = fm(o[1], a[2]) - fm(o[2], a[1]);
        q[1] = fm(o[2], a[0]) - fm(o[0], a[2]);
        q[2] = fm(o[0], a[1]) - fm(o[1], a[0]);
        det = fm(a[0], p[0]) + fm(a[1], p[1]) + fm(a[2], p[2]);
        un  = fdiv(fm(o[0], p[0]) + fm(o[1], p[1]) + fm(o[2], p[2]), det);
        vn  = fdiv(fm(d[0], q[0]) + fm(d[1], q[1]) + fm(d[2], q[2]), det);
        tn  = fdiv(fm(b[0], q[0]) + fm(b[1], q[1]) + fm(b[2], q[2]), det);
        return {det[31:0], un[31:0], vn[31:0], tn[31:0]};
    endfunction

    logic [127:0] m3, m2;
    assign m3 = moller(bus3.dp_rdir, bus3.dp_t1, bus3.dp_e1, bus3.dp_e2);
    assign m2 = moller(bus2.dp_rdir, bus2.dp_t1, bus2.dp_e1, bus2.dp_e2);

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus3.dp_det <= '0; bus3.dp_u <= '0; bus3.dp_v <= '0; bus3.dp_t <= '0;
        end else begin
            if (!bus3.dp_sel1) begin bus3.dp_det <= m3[127:96]; bus3.dp_u <= m3[95:64]; end
            if (bus3.dp_sel1) bus3.dp_v <= m3[63:32];
            if (bus3.dp_sel2) bus3.dp_t <= m3[31:0];
        end
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus2.dp_det <= '0; bus2.dp_u <= '0; bus2.dp_v <= '0; bus2.dp_t <= '0;
        end else begin
            if (!bus2.dp_sel1) begin bus2.dp_det <= m2[127:96]; bus2.dp_u <= m2[95:64]; end
            if (bus2.dp_sel1) bus2.dp_v <= m2[63:32];
            if (bus2.dp_sel2) bus2.dp_t <= m2[31:0];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (bus2.req_valid && bus2.req_ready) hs2 <= cyc;
    end

    always @(negedge clock) begin
        if (reset_n && bus2.res_valid) begin
            if (q2.size() == 0) chk("pc2_unexpected_result", 1, 0);
            else begin
                e2v = q2.pop_front();
                chk("pc2_latency", 64'(cyc - hs2), 64'(e2v.lat));
                chk("pc2_hit", bus2.res_hit, e2v.hit);
                chk("pc2_t", bus2.res_t, e2v.t);
                chk("pc2_u", bus2.res_u, e2v.u);
                chk("pc2_v", bus2.res_v, e2v.v);
            end
        end
    end

    function automatic logic [95:0] vec(input logic [31:0] x, y, z);
        return {x, y, z};
    endfunction

    function automatic logic [1:0] exp_sel(input int n, input bit dfail);
        int k;
        k = n - 2;
        if (dfail) return (k < 3) ? 2'b00 : 2'b10;
        if (k < 3) return 2'b00;
        if (k < 6) return 2'b10;
        if (k < 9) return 2'b11;
        return 2'b10;
    endfunction

    task automatic start_req(input logic [95:0] orig, input logic [95:0] dir);
        int n;
        n = 0;
        @(negedge clock);
        while (!bus3.req_ready && n < 50) begin @(negedge clock); n++; end
        if (n >= 50) chk("req_ready_timeout", 0, 1);
        bus3.ray_orig = orig;
        bus3.ray_dir  = dir;
        bus3.vert0    = vec(0, 0, 0);
        bus3.vert1    = vec(ONE, 0, 0);
        bus3.vert2    = vec(0, ONE, 0);
        bus3.req_valid = 1'b1;
        @(posedge clock);
        #1;
        bus3.req_valid = 1'b0;
        bus3.ray_orig = {$urandom, $urandom, $urandom};
        bus3.ray_dir  = {$urandom, $urandom, $urandom};
        bus3.vert0    = {$urandom, $urandom, $urandom};
        bus3.vert1    = {$urandom, $urandom, $urandom};
        bus3.vert2    = {$urandom, $urandom, $urandom};
    endtask

    task automatic run_req(input string name, input logic [95:0] orig, input logic [95:0] dir,
                           input logic hit, input logic [31:0] t, u, v,
                           input bit dfail, input int stall);
        exp_t e;
        int n;
        e.hit = hit; e.t = t; e.u = u; e.v = v;
        e.lat = dfail ? 6 : 12;
        q3.push_back(e);
        e.lat = dfail ? 5 : 9;
        q2.push_back(e);
        bus3.res_ready = (stall == 0);
        start_req(orig, dir);
        n = 1;
        while (n < 40) begin
            @(negedge clock);
            if (bus3.res_valid) break;
            chk($sformatf("%s_busy_ready_c%0d", name, n), bus3.req_ready, 0);
            if (n >= 2)
                chk($sformatf("%s_sel_c%0d", name, n), {bus3.dp_sel1, bus3.dp_sel2}, exp_sel(n, dfail));
            @(posedge clock);
            n++;
        end
        e = q3.pop_front();
        chk({name, "_latency"}, 64'(n), 64'(e.lat));
        chk({name, "_hit"}, bus3.res_hit, e.hit);
        chk({name, "_t"}, bus3.res_t, e.t);
        chk({name, "_u"}, bus3.res_u, e.u);
        chk({name, "_v"}, bus3.res_v, e.v);
        for (int i = 0; i < stall; i++) begin
            @(posedge clock);
            @(negedge clock);
            chk($sformatf("%s_stall%0d_valid", name, i), bus3.res_valid, 1);
            chk($sformatf("%s_stall%0d_ready", name, i), bus3.req_ready, 0);
            chk($sformatf("%s_stall%0d_res", name, i),
                {bus3.res_hit, bus3.res_t, bus3.res_u[30:0]}, {e.hit, e.t, e.u[30:0]});
            chk($sformatf("%s_stall%0d_v", name, i), bus3.res_v, e.v);
        end
        bus3.res_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk({name, "_post_req_ready"}, bus3.req_ready, 1);
        chk({name, "_post_res_valid"}, bus3.res_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        bus3.req_valid = 1'b0;
        bus3.res_ready = 1'b0;
        bus3.ray_orig = '0; bus3.ray_dir = '0;
        bus3.vert0 = '0; bus3.vert1 = '0; bus3.vert2 = '0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_req_ready", bus3.req_ready, 0);
        chk("reset_res_valid", bus3.res_valid, 0);
        chk("reset_res", {bus3.res_hit, bus3.res_t, bus3.res_u}, 0);
        chk("reset_res_v", bus3.res_v, 0);
        chk("reset_sel", {bus3.dp_sel1, bus3.dp_sel2}, 0);
        chk("reset_dp", |{bus3.dp_rdir, bus3.dp_t1, bus3.dp_e1, bus3.dp_e2}, 0);
        reset_n = 1'b1;
        #1 chk("release_req_ready_low", bus3.req_ready, 0);
        @(negedge clock);
        chk("release_req_ready_high", bus3.req_ready, 1);

        run_req("centre",   vec(32'h4000, 32'h4000, NEG1), vec(0, 0, ONE), 1, ONE, 32'h4000, 32'h4000, 0, 0);
        run_req("parallel", vec(32'h4000, 32'h4000, NEG1), vec(ONE, 0, 0), 0, 0, 0, 0, 1, 0);
        run_req("det_eps",  vec(32'h4000, 32'h4000, NEG1), vec(0, 0, 32'h1), 0, 0, 0, 0, 1, 0);
        run_req("outside",  vec(ONE, ONE, NEG1), vec(0, 0, ONE), 0, ONE, ONE, ONE, 0, 0);
        run_req("edge",     vec(32'h8000, 32'h8000, NEG1), vec(0, 0, ONE), 1, ONE, 32'h8000, 32'h8000, 0, 0);
        run_req("behind",   vec(32'h4000, 32'h4000, ONE), vec(0, 0, ONE), 0, NEG1, 32'h4000, 32'h4000, 0, 0);
        run_req("stall",    vec(32'h4000, 32'h4000, NEG1), vec(0, 0, ONE), 1, ONE, 32'h4000, 32'h4000, 0, 5);

        // Abort a request while it sits in PH_V.
        bus3.res_ready = 1'b1;
        start_req(vec(32'h4000, 32'h4000, NEG1), vec(0, 0, ONE));
        repeat (5) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_req_ready", bus3.req_ready, 0);
        chk("abort_res_valid", bus3.res_valid, 0);
        chk("abort_res", {bus3.res_hit, bus3.res_t, bus3.res_u}, 0);
        chk("abort_res_v", bus3.res_v, 0);
        chk("abort_sel", {bus3.dp_sel1, bus3.dp_sel2}, 0);
        chk("abort_dp", |{bus3.dp_rdir, bus3.dp_t1, bus3.dp_e1, bus3.dp_e2}, 0);
        chk("abort_pc2_sel", {bus2.dp_sel1, bus2.dp_sel2}, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1 chk("abort_release_ready_low", bus3.req_ready, 0);
        seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            if (bus3.res_valid || bus2.res_valid) seen = 1'b1;
        end
        chk("abort_no_result", seen, 0);
        chk("abort_idle_ready", bus3.req_ready, 1);

        run_req("after_reset", vec(32'h4000, 32'h4000, NEG1), vec(0, 0, ONE), 1, ONE, 32'h4000, 32'h4000, 0, 0);

        repeat (3) @(negedge clock);
        chk("pc2_queue_drained", 64'(q2.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/intersection_sequencer.md
# intersection_sequencer

Control and operand front-end for the ray/triangle intersection datapath. Accepts one ray plus one triangle per request and derives the edge and offset vectors. Steps the datapath through its three select phases (u, v, t), samples det/u/v/t back, and applies the hit test. Returns a single registered hit/t/u/v result over a valid/ready handshake. Sits between the ray scheduler and the intersection datapath; it is the initiator that drives that datapath's sel1/sel2 protocol.

## Interface
- FIXED_W, 32, width of one fixed-point scalar (two's complement)
- FRAC_W, 16, fractional bits; ONE = 1 << FRAC_W
- PHASE_CYC, 3, cycles each datapath phase is held (min 2)
- EPS, 1, raw-LSB threshold for det and t rejection
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- ray_orig, ray_dir, vert0, vert1, vert2  in  3*FIXED_W each  vectors packed {x,y,z}, x in MSBs
- dp_rdir, dp_t1, dp_e1, dp_e2  out  3*FIXED_W each  datapath operands
- dp_sel1, dp_sel2  out  1  datapath phase selects
- dp_det, dp_u, dp_v, dp_t  in  FIXED_W each  datapath results
- res_valid  out  1  result valid
- res_ready  in  1  result consumed when res_valid & res_ready
- res_hit  out  1  intersection accepted
- res_t, res_u, res_v  out  FIXED_W each  captured distance and barycentrics

## Operation
- States: IDLE, LOAD, PH_U, PH_V, PH_T, EVAL, DONE.
- IDLE
  - req_ready=1.
  - On handshake, register ray_orig, ray_dir and the vertices, then go to LOAD.
- LOAD (1 cycle)
  - Register dp_rdir=ray_dir.
  - Register dp_e1=vert1-vert0, dp_e2=vert2-vert0, dp_t1=ray_orig-vert0.
  - Subtraction is per component, FIXED_W-bit wrapping, no saturation.
  - Next state: PH_U.
- PH_U (sel1=0, sel2=0, PHASE_CYC cycles)
  - Capture dp_det on the last cycle.
  - If |det| <= EPS, go to EVAL with det_fail set. Otherwise go to PH_V.
- PH_V (sel1=1, sel2=0, PHASE_CYC cycles)
  - Capture dp_u on the first cycle; the datapath u register is frozen once sel1=1.
- PH_T (sel1=1, sel2=1, PHASE_CYC cycles)
  - Capture dp_v on the first cycle.
- EVAL (sel1=1, sel2=0, 1 cycle)
  - Capture dp_t; the datapath t register is frozen once sel2=0.
  - Compute hit = !det_fail & u>=0 & v>=0 & (u+v)<=ONE & t>EPS.
  - u+v is computed at FIXED_W+1 bits, so there is no overflow.
  - The u+v<=ONE comparison is inclusive.
  - Load res_* and go to DONE.
- DONE
  - res_valid=1.
  - res_hit/t/u/v are held stable until res_ready.
  - On handshake go to IDLE.
- On det_fail: res_hit=0 and res_t=res_u=res_v=0.
- On a miss from the u/v/t checks: res_t/u/v carry the captured values.
- |det| is computed without overflow. The most negative det is treated as > EPS.
- dp_rdir/t1/e1/e2 hold their values from LOAD until the next LOAD.
- Inputs are ignored outside the IDLE handshake.

## Timing
- Reset (async assert, sync release) drives every output low or zero:
  - req_ready=0, res_valid=0, res_hit=0, res_t/u/v=0, dp_sel1=dp_sel2=0, all dp_* vectors=0.
- req_ready rises 1 cycle after reset release.
- Reset mid-operation aborts the request. Nothing is emitted, and state returns to IDLE.
- Request handshake at cycle 0: LOAD is cycle 1, PH_U starts at cycle 2.
- Normal path: res_valid asserts at cycle 3*PHASE_CYC+3 (default 12).
- det early-out: res_valid asserts at cycle PHASE_CYC+3 (default 6).
- req_ready=0 from the handshake cycle+1 until the cycle after the result handshake. One request is in flight at a time.
- res_ready held low stalls in DONE indefinitely with outputs unchanged.
- res_ready high when res_valid rises: handshake in that cycle, req_ready=1 next cycle.
- dp_sel1/dp_sel2 are registered and glitch-free; they change only on state transitions.

## Test plan
Bench uses a behavioural Möller datapath model as responder. All values are Q16.16 (1.0 = 0x10000).
- Centre hit
  - Stimulus: v0=(0,0,0), v1=(1,0,0), v2=(0,1,0), orig=(0.25,0.25,-1), dir=(0,0,1).
  - Required: res_valid at cycle 12; hit=1, t=0x10000, u=0x4000, v=0x4000.
- Parallel ray
  - Stimulus: dir=(1,0,0), same triangle.
  - Required: det=0, res_valid at cycle 6; hit=0, t=u=v=0; no PH_V/PH_T selects observed.
- Outside, edge inclusive, and behind
  - orig=(1,1,-1) -> hit=0, u+v=0x20000.
  - orig=(0.5,0.5,-1) -> hit=1 (u+v exactly ONE).
  - orig=(0.25,0.25,1), dir=(0,0,1) -> t=-0x10000, hit=0.
- Backpressure
  - Stimulus: res_ready low for 5 cycles after res_valid.
  - Required: res_* stable, req_ready=0 throughout; after the handshake, req_ready=1 on the next cycle.
- Select sequence
  - Check dp_sel1/sel2 per cycle against 00×3, 10×3, 11×3, 10 for PHASE_CYC=3.
  - Repeat with PHASE_CYC=2: latency 9.
- Reset
  - Stimulus: assert reset_n=0 during PH_V.
  - Required: all outputs zero immediately; no res_valid. After release, a new request completes normally with correct values.
